lifo_pop_reader: RTL and testbench
==================================

// Module: lifo_pop_reader
// PURPOSE
//  Reader-side controller for the lifo_buffer read port. On a start pulse it pops up to
//  req_count entries (or until empty), issuing single-cycle read strobes and qualifying the
//  registered dataout/val response. Popped words go to a valid/ready stream. Sits between a
//  LIFO instance and any downstream consumer; the LIFO write side stays external.
// PARAMETERS
//  DATA_W  10  word width; must match the attached LIFO.
//  CNT_W   4   width of req_count/popped_count; max pops per drain = 2**CNT_W-1.
// PORTS
//  clock           in   1       rising-edge clock
//  reset_n         in   1       asynchronous, active-low reset
//  start           in   1       1-cycle pulse: begin drain; ignored while busy
//  req_count       in   CNT_W   pops requested, sampled on start; 0 = drain until empty
//  busy            out  1       high from cycle after accepted start until done
//  done            out  1       1-cycle pulse at end of drain
//  popped_count    out  CNT_W   words popped in current/last drain; held until next start
//  empty_seen      out  1       last drain ended on an empty response; held until next start
//  lifo_read       out  1       read strobe to LIFO, never high two consecutive cycles
//  lifo_write_mon  in   1       copy of LIFO write input (collision avoidance)
//  lifo_dataout    in   DATA_W  LIFO registered read data
//  lifo_val        in   1       LIFO registered valid
//  out_data        out  DATA_W  popped word
//  out_valid       out  1       out_data valid
//  out_ready       in   1       downstream accept; transfer when out_valid & out_ready
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; lifo_read drops asynchronously.
//  FSM: IDLE -> ISSUE -> WAIT -> {ISSUE | FLUSH} -> IDLE.
//   IDLE : start=1 -> latch req_count, clear popped_count/empty_seen, go ISSUE.
//   ISSUE: lifo_read=1 only if lifo_write_mon=0 AND (out_valid=0 OR out_ready=1);
//          else hold in ISSUE, lifo_read=0. Strobe issued -> WAIT.
//   WAIT : lifo_read=0. Sample lifo_val/lifo_dataout this cycle (LIFO responds 1 cycle
//          after strobe). val=1: load out_data, out_valid<=1, popped_count+1.
//          val=0: empty_seen<=1, nothing loaded -> FLUSH.
//          After a pop: target reached (req_count!=0 and popped==req_count) -> FLUSH;
//          req_count=0 and popped_count saturates at all-ones -> FLUSH, empty_seen=0;
//          otherwise -> ISSUE.
//   FLUSH: wait until out_valid=0 (last word accepted); then done=1 for one cycle,
//          busy<=0 -> IDLE. done never precedes acceptance of the final word.
//  lifo_val is sampled only in WAIT; LIFO val is sticky, never trust it elsewhere.
//  Latency: start@0 -> lifo_read@1 -> sample@2 -> out_valid@3. Max rate 1 word / 2 cycles.
//  out_valid held with out_data stable until out_ready; no overwrite of an unaccepted word.
//  start during busy: ignored, no state change. start and done same cycle: start ignored.
//  Reset mid-drain: abort immediately, pending out word discarded, no done pulse.
// STRUCTURE
//  Shared include lifo_defs.vh: FSM state localparams (IDLE/ISSUE/WAIT/FLUSH, 2-bit),
//  default DATA_W. One sub-module: lifo_out_reg (single-entry valid/ready holding register,
//  load/out_valid/out_ready); FSM and counters stay in the top.
// TESTING
//  LIFO holds 3,7,9 (9 top); start req_count=2, out_ready=1 -> out 9,7; popped=2;
//   empty_seen=0; done once; exactly 2 lifo_read strobes.
//  Same LIFO, req_count=0 -> out 9,7,3; 4th read returns val=0 -> empty_seen=1, popped=3.
//  Empty LIFO, req_count=5 -> one strobe, no out_valid, done, popped=0, empty_seen=1.
//  out_ready=0 for 10 cycles after first word -> out_data 9 stable, no 2nd strobe;
//   release -> 7 follows; done only after 7 accepted.
//  lifo_write_mon=1 for 3 cycles in ISSUE -> lifo_read stays 0, then issues; data correct.
//  reset_n low in WAIT -> busy/out_valid/lifo_read 0 same cycle; no done;
//   fresh start works normally.

Source files
------------

// File: rtl/lifo_pop_reader_pkg.sv
// Shared definitions for the LIFO pop reader: controller states and default widths.
package lifo_pop_reader_pkg;

  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/lifo_pop_reader_if.sv
// Control, LIFO read-port and output-stream signals of the pop reader.
interface lifo_pop_reader_if #(
  parameter int unsigned DATA_W = lifo_pop_reader_pkg::DEF_DATA_W,
  parameter int unsigned CNT_W  = lifo_pop_reader_pkg::DEF_CNT_W
);

  logic              start;
  logic [CNT_W-1:0]  req_count;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  popped_count;
  logic              empty_seen;
  logic              lifo_read;
  logic              lifo_write_mon;
  logic [DATA_W-1:0] lifo_dataout;
  logic              lifo_val;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  start, req_count, lifo_write_mon, lifo_dataout, lifo_val, out_ready,
    output busy, done, popped_count, empty_seen, lifo_read, out_data, out_valid
  );

  modport master (
    output start, req_count, lifo_write_mon, lifo_dataout, lifo_val, out_ready,
    input  busy, done, popped_count, empty_seen, lifo_read, out_data, out_valid
  );

endinterface

// File: rtl/lifo_pop_reader_out_reg.sv
// Single-entry valid/ready holding register for popped words.
module lifo_out_reg #(
  parameter int unsigned DATA_W = lifo_pop_reader_pkg::DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lifo_pop_reader.sv
// Drains up to req_count words from a LIFO read port into a valid/ready stream.
module lifo_pop_reader
  import lifo_pop_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  lifo_pop_reader_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_req;
  logic [CNT_W-1:0]  r_popped;
  logic              r_empty_seen;
  logic [CNT_W-1:0]  w_popped_inc;
  logic              w_target;
  logic              w_accept;
  logic              w_read;
  logic              w_done;
  logic              w_load;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;

  assign w_accept     = (r_state == ST_IDLE) && bus.start;
  assign w_popped_inc = r_popped + 1'b1;
  // req_count of zero means "until empty", bounded by the counter saturating.
  assign w_target     = (r_req != '0) ? (w_popped_inc == r_req) : (&w_popped_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_read = 1'b0;
    w_done = 1'b0;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_ISSUE;
      end
      // Only strobe when the holding register is guaranteed free at the response.
      ST_ISSUE: begin
        if (!bus.lifo_write_mon && (!w_out_valid || bus.out_ready)) begin
          w_read = 1'b1;
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.lifo_val) begin
          w_load = 1'b1;
          w_next = w_target ? ST_FLUSH : ST_ISSUE;
        end else begin
          w_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!w_out_valid) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req        <= '0;
      r_popped     <= '0;
      r_empty_seen <= 1'b0;
    end else if (w_accept) begin
      r_req        <= bus.req_count;
      r_popped     <= '0;
      r_empty_seen <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (bus.lifo_val) r_popped     <= w_popped_inc;
      else              r_empty_seen <= 1'b1;
    end
  end

  lifo_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_data  (bus.lifo_dataout),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_data)
  );

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = w_done;
  assign bus.popped_count = r_popped;
  assign bus.empty_seen   = r_empty_seen;
  assign bus.lifo_read    = w_read;
  assign bus.out_data     = w_out_data;
  assign bus.out_valid    = w_out_valid;

endmodule

// File: tb/tb_lifo_pop_reader.sv
// Scoreboard bench for lifo_pop_reader with a behavioural LIFO and randomized drains.
module tb_lifo_pop_reader;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lifo_pop_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  lifo_pop_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int unsigned popped;
    int unsigned empty;
    int unsigned strobes;
  } drain_t;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] stack[$];
  logic [DW-1:0] sb[$];
  drain_t        exp_drain[$];

  int   ready_mode   = 0;
  logic manual_ready = 1'b1;
  int   wm_mode      = 0;
  logic manual_wm    = 1'b0;

  int   strobes = 0;
  int   n_done  = 0;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Behavioural LIFO read port: registered data, sticky valid.
  always @(posedge clock) begin
    if (bus.lifo_read) begin
      if (stack.size() > 0) begin
        bus.lifo_dataout <= stack.pop_back();
        bus.lifo_val     <= 1'b1;
      end else begin
        bus.lifo_val     <= 1'b0;
      end
    end
  end

  initial begin
    bus.out_ready      = 1'b1;
    bus.lifo_write_mon = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = manual_ready;
      endcase
      if (wm_mode == 0) bus.lifo_write_mon = manual_wm;
      else              bus.lifo_write_mon = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: scoreboard pops, strobe rules, stall stability, end-of-drain status.
  logic          prev_read  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  drain_t        mon_e;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_read  = 1'b0;
        prev_stall = 1'b0;
        strobes    = 0;
      end else begin
        if (bus.lifo_read) begin
          strobes++;
          check("no_back_to_back_read", 32'(prev_read), 0);
          check("read_during_write_mon", 32'(bus.lifo_write_mon), 0);
        end
        prev_read = bus.lifo_read;
        if (prev_stall && bus.out_valid)
          check("out_data_stable", 32'(bus.out_data), 32'(prev_data));
        if (bus.out_valid && bus.out_ready) begin
          check("word_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) check("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.done) begin
          n_done++;
          check("done_expected", 32'(exp_drain.size() != 0), 1);
          if (exp_drain.size() != 0) begin
            mon_e = exp_drain.pop_front();
            check("popped_count", 32'(bus.popped_count), mon_e.popped);
            check("empty_seen", 32'(bus.empty_seen), mon_e.empty);
            check("strobe_count", strobes, mon_e.strobes);
            check("words_left_at_done", sb.size(), 0);
            check("out_valid_at_done", 32'(bus.out_valid), 0);
          end
          strobes = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic load_stack(input int unsigned depth);
    stack.delete();
    for (int unsigned i = 0; i < depth; i++) stack.push_back(DW'($urandom));
  endtask

  task automatic load_379();
    stack.delete();
    stack.push_back(10'd3);
    stack.push_back(10'd7);
    stack.push_back(10'd9);
  endtask

  int done_before;

  task automatic begin_drain(input int unsigned req);
    drain_t      e;
    int unsigned depth = stack.size();
    int unsigned lim   = (req == 0) ? ((1 << CW) - 1) : req;
    int unsigned n     = (depth < lim) ? depth : lim;
    for (int unsigned i = 0; i < n; i++) sb.push_back(stack[depth - 1 - i]);
    e.popped  = n;
    e.empty   = (depth < lim) ? 1 : 0;
    e.strobes = n + e.empty;
    exp_drain.push_back(e);
    done_before = n_done;
    @(posedge clock);
    #1;
    bus.start     = 1'b1;
    bus.req_count = CW'(req);
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.req_count = CW'($urandom);
  endtask

  task automatic finish_drain(input int budget);
    int cyc = 0;
    while (n_done == done_before && cyc < budget) begin
      @(posedge clock);
      cyc++;
    end
    check("drain_completed", 32'(n_done - done_before), 1);
    repeat (3) @(posedge clock);
    #1;
    check("single_done", 32'(n_done - done_before), 1);
    check("busy_after_done", 32'(bus.busy), 0);
    sb.delete();
    exp_drain.delete();
  endtask

  initial begin
    int cyc;
    bus.start        = 1'b0;
    bus.req_count    = '0;
    bus.lifo_dataout = '0;
    bus.lifo_val     = 1'b0;

    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_popped", 32'(bus.popped_count), 0);
    check("rst_empty_seen", 32'(bus.empty_seen), 0);
    check("rst_lifo_read", 32'(bus.lifo_read), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // req_count=2 on 3,7,9: expect 9,7
    load_379();
    begin_drain(2);
    finish_drain(100);

    // until empty: 9,7,3 then an empty response
    load_379();
    begin_drain(0);
    finish_drain(100);

    // empty LIFO: one strobe, no words
    stack.delete();
    begin_drain(5);
    finish_drain(100);

    // downstream stall after first word
    load_379();
    ready_mode   = 2;
    manual_ready = 1'b0;
    begin_drain(2);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("first_word_valid", 32'(bus.out_valid), 1);
    check("first_word_value", 32'(bus.out_data), 9);
    repeat (10) @(negedge clock);
    check("stalled_strobes", strobes, 1);
    check("stalled_valid", 32'(bus.out_valid), 1);
    @(posedge clock);
    #1;
    manual_ready = 1'b1;
    finish_drain(100);
    ready_mode = 0;

    // write collision held for 3 cycles in ISSUE
    load_379();
    manual_wm = 1'b1;
    begin_drain(0);
    repeat (3) @(negedge clock);
    check("wm_no_strobe", strobes, 0);
    check("wm_busy", 32'(bus.busy), 1);
    @(posedge clock);
    #1;
    manual_wm = 1'b0;
    finish_drain(100);

    // reset while waiting for the LIFO response
    load_379();
    begin_drain(2);
    cyc = 0;
    while (!bus.lifo_read && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("pre_reset_strobe", 32'(bus.lifo_read), 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_lifo_read", 32'(bus.lifo_read), 0);
    sb.delete();
    exp_drain.delete();
    done_before = n_done;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("no_done_after_reset", 32'(n_done - done_before), 0);
    load_379();
    begin_drain(2);
    finish_drain(100);

    // randomized drains, with a stray start pulse while busy
    for (int it = 0; it < 24; it++) begin
      ready_mode = $urandom_range(0, 1);
      wm_mode    = $urandom_range(0, 1);
      load_stack($urandom_range(0, 18));
      begin
        int unsigned req = $urandom_range(0, 15);
        int unsigned lim = (req == 0) ? 15 : req;
        int unsigned n   = (stack.size() < lim) ? stack.size() : lim;
        begin_drain(req);
        if (n >= 2) begin
          @(posedge clock);
          #1;
          bus.start     = 1'b1;
          bus.req_count = CW'($urandom_range(1, 15));
          @(posedge clock);
          #1;
          bus.start     = 1'b0;
        end
      end
      finish_drain(600);
    end
    ready_mode = 0;
    wm_mode    = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
